hour_counter_bcd: RTL and testbench

//  Parametrised hours counter for the digital clock; successor to the fixed mod-24 reset logic.

---
 rtl/hour_counter_bcd_pkg.sv | 41 ++++
 rtl/hour_counter_bcd_if.sv | 29 ++
 rtl/hour_counter_bcd_disp_fmt.sv | 42 ++++
 rtl/hour_counter_bcd.sv | 118 +++++++++++
 tb/tb_hour_counter_bcd.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hour_counter_bcd_pkg.sv
// Shared clock constants, action codes and BCD helpers for the hours counter.
// Imported by the interface, the display formatter and the top.
package hour_counter_bcd_pkg;

    localparam int HOURS_PER_DAY = 24;
    localparam int NOON          = 12;
    localparam int BCD_W         = 4;
    localparam int BIN7_W        = 7;

    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_FIX,
        ACT_LOAD,
        ACT_LDERR,
        ACT_INC,
        ACT_DEC,
        ACT_TICK
    } hour_act_e;

    typedef struct packed {
        logic [BCD_W-1:0] tens;
        logic [BCD_W-1:0] units;
    } bcd2_t;

    // Shift-add-3 conversion; inputs never exceed 99 here.
    function automatic bcd2_t bin2bcd(input logic [BIN7_W-1:0] b);
        logic [14:0] s;
        s = {8'd0, b};
        for (int i = 0; i < BIN7_W; i++) begin
            if (s[10:7] >= 4'd5) s[10:7] = s[10:7] + 4'd3;
            if (s[14:11] >= 4'd5) s[14:11] = s[14:11] + 4'd3;
            s = s << 1;
        end
        return bcd2_t'(s[14:7]);
    endfunction

    function automatic logic bcd_digit_ok(input logic [BCD_W-1:0] d);
        return d <= 4'd9;
    endfunction

endpackage

// File: rtl/hour_counter_bcd_if.sv
// Control/display bundle between the time-set logic, the hours counter
// and the display mux.
interface hour_counter_bcd_if;
    import hour_counter_bcd_pkg::*;

    logic             en;
    logic             mode12;
    logic             load;
    logic [BCD_W-1:0] ld_tens;
    logic [BCD_W-1:0] ld_units;
    logic             inc;
    logic             dec;
    logic [BCD_W-1:0] hour_tens;
    logic [BCD_W-1:0] hour_units;
    logic             pm;
    logic             day_carry;
    logic             load_err;

    modport master (
        output en, mode12, load, ld_tens, ld_units, inc, dec,
        input  hour_tens, hour_units, pm, day_carry, load_err
    );

    modport slave (
        input  en, mode12, load, ld_tens, ld_units, inc, dec,
        output hour_tens, hour_units, pm, day_carry, load_err
    );

endinterface

// File: rtl/hour_counter_bcd_disp_fmt.sv
// Combinational display formatter: binary hour count plus 12h/24h
// selection to two BCD digits and a pm flag.
module hour_disp_fmt
    import hour_counter_bcd_pkg::*;
#(
    parameter int CNT_W     = 5,
    parameter int DISP12_EN = 1
) (
    input  logic [CNT_W-1:0] i_cnt,
    input  logic             i_mode12,
    output logic [BCD_W-1:0] o_tens,
    output logic [BCD_W-1:0] o_units,
    output logic             o_pm
);

    logic [BIN7_W-1:0] w_cnt7;
    logic [BIN7_W-1:0] w_disp;
    logic              w_m12;
    bcd2_t             w_bcd;

    assign w_cnt7 = BIN7_W'(i_cnt);
    assign w_m12  = i_mode12 & (DISP12_EN != 0);

    // 12h view: midnight shows 12 (am), afternoon hours fold down by 12.
    always_comb begin
        w_disp = w_cnt7;
        o_pm   = 1'b0;
        if (w_m12) begin
            o_pm = (w_cnt7 >= BIN7_W'(NOON));
            if (w_cnt7 == '0) begin
                w_disp = BIN7_W'(NOON);
            end else if (w_cnt7 > BIN7_W'(NOON)) begin
                w_disp = w_cnt7 - BIN7_W'(NOON);
            end
        end
    end

    assign w_bcd   = bin2bcd(w_disp);
    assign o_tens  = w_bcd.tens;
    assign o_units = w_bcd.units;

endmodule

// File: rtl/hour_counter_bcd.sv
// Hours counter: modulo-WRAP binary count with BCD load, inc/dec time-set,
// load validation, day-carry pulse and 12h/24h BCD display.
module hour_counter_bcd
    import hour_counter_bcd_pkg::*;
#(
    parameter int WRAP       = HOURS_PER_DAY,
    parameter int RESET_HOUR = 0,
    parameter int DISP12_EN  = 1
) (
    input logic                clk,
    input logic                rst,
    hour_counter_bcd_if.slave  bus
);

    localparam int CNT_W = $clog2(WRAP);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WRAP - 1);
    localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(RESET_HOUR);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    if (WRAP < 2 || WRAP > 99) begin : g_bad_wrap
        $error("hour_counter_bcd: WRAP must be 2..99");
    end
    if (RESET_HOUR < 0 || RESET_HOUR >= WRAP) begin : g_bad_rst
        $error("hour_counter_bcd: RESET_HOUR must be below WRAP");
    end
    if (DISP12_EN != 0 && WRAP != HOURS_PER_DAY) begin : g_bad_disp
        $error("hour_counter_bcd: 12h display needs WRAP of 24");
    end

    logic [CNT_W-1:0] r_cnt;
    logic             r_day_carry;
    logic             r_load_err;

    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_carry_nxt;
    logic             w_err_nxt;
    logic             w_in_range;
    logic             w_at_max;
    logic             w_at_zero;
    logic [7:0]       w_ld_val;
    logic             w_ld_ok;
    hour_act_e        w_act;

    assign w_in_range = (r_cnt <= CNT_MAX);
    assign w_at_max   = (r_cnt == CNT_MAX);
    assign w_at_zero  = (r_cnt == '0);

    assign w_ld_val = 8'(bus.ld_tens) * 8'd10 + 8'(bus.ld_units);
    assign w_ld_ok  = bcd_digit_ok(bus.ld_tens)
                    & bcd_digit_ok(bus.ld_units)
                    & (w_ld_val < 8'(WRAP));

    // One action per edge; an upset count is repaired before anything else.
    always_comb begin
        w_act = ACT_NONE;
        if (!w_in_range) begin
            w_act = ACT_FIX;
        end else if (bus.load) begin
            w_act = w_ld_ok ? ACT_LOAD : ACT_LDERR;
        end else if (bus.inc ^ bus.dec) begin
            w_act = bus.inc ? ACT_INC : ACT_DEC;
        end else if (bus.en) begin
            w_act = ACT_TICK;
        end
    end

    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_carry_nxt = 1'b0;
        w_err_nxt   = 1'b0;
        case (w_act)
            ACT_FIX:   w_cnt_nxt = '0;
            ACT_LOAD:  w_cnt_nxt = CNT_W'(w_ld_val);
            ACT_LDERR: w_err_nxt = 1'b1;
            ACT_INC:   w_cnt_nxt = w_at_max ? '0 : r_cnt + CNT_ONE;
            ACT_DEC:   w_cnt_nxt = w_at_zero ? CNT_MAX : r_cnt - CNT_ONE;
            ACT_TICK: begin
                w_cnt_nxt   = w_at_max ? '0 : r_cnt + CNT_ONE;
                w_carry_nxt = w_at_max;
            end
            default:   w_cnt_nxt = r_cnt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= CNT_RST;
            r_day_carry <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_day_carry <= w_carry_nxt;
            r_load_err  <= w_err_nxt;
        end
    end

    logic [BCD_W-1:0] w_tens;
    logic [BCD_W-1:0] w_units;
    logic             w_pm;

    hour_disp_fmt #(
        .CNT_W     (CNT_W),
        .DISP12_EN (DISP12_EN)
    ) u_fmt (
        .i_cnt    (r_cnt),
        .i_mode12 (bus.mode12),
        .o_tens   (w_tens),
        .o_units  (w_units),
        .o_pm     (w_pm)
    );

    assign bus.hour_tens  = w_tens;
    assign bus.hour_units = w_units;
    assign bus.pm         = w_pm;
    assign bus.day_carry  = r_day_carry;
    assign bus.load_err   = r_load_err;

endmodule

// File: tb/tb_hour_counter_bcd.sv
// Randomised and directed bench for hour_counter_bcd: a 24h/12h-display
// instance and a WRAP=12 instance driven in lockstep against a reference model.
module tb_hour_counter_bcd;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mode12 = 1'b0;

    always #5 clk = ~clk;

    hour_counter_bcd_if a ();
    hour_counter_bcd_if b ();

    hour_counter_bcd #(.WRAP(24), .RESET_HOUR(0), .DISP12_EN(1)) u_a (
        .clk (clk),
        .rst (rst),
        .bus (a)
    );

    hour_counter_bcd #(.WRAP(12), .RESET_HOUR(0), .DISP12_EN(0)) u_b (
        .clk (clk),
        .rst (rst),
        .bus (b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int m_cnt[2];
    bit m_carry[2];
    bit m_err[2];
    int m_wrap[2] = '{24, 12};

    function automatic logic [10:0] exp_vec(input int k);
        int  c;
        int  h;
        bit  p;
        c = m_cnt[k];
        h = c;
        p = 1'b0;
        if (k == 0 && mode12) begin
            h = (c % 12 == 0) ? 12 : c % 12;
            p = (c >= 12);
        end
        return {4'(h / 10), 4'(h % 10), p, m_carry[k], m_err[k]};
    endfunction

    function automatic logic [10:0] got_a();
        return {a.hour_tens, a.hour_units, a.pm, a.day_carry, a.load_err};
    endfunction

    function automatic logic [10:0] got_b();
        return {b.hour_tens, b.hour_units, b.pm, b.day_carry, b.load_err};
    endfunction

    task automatic drive(input bit en, input bit ld, input bit inc,
                         input bit dec, input int t, input int u);
        a.en = en; a.load = ld; a.inc = inc; a.dec = dec;
        b.en = en; b.load = ld; b.inc = inc; b.dec = dec;
        a.ld_tens = 4'(t); a.ld_units = 4'(u);
        b.ld_tens = 4'(t); b.ld_units = 4'(u);
        a.mode12 = mode12; b.mode12 = mode12;
    endtask

    // Apply one cycle of inputs, advance the model, and settle past the edge.
    task automatic cyc(input bit en, input bit ld, input bit inc,
                       input bit dec, input int t, input int u);
        int v;
        drive(en, ld, inc, dec, t, u);
        for (int k = 0; k < 2; k++) begin
            m_carry[k] = 1'b0;
            m_err[k] = 1'b0;
            v = t * 10 + u;
            if (ld) begin
                if (t <= 9 && u <= 9 && v < m_wrap[k]) m_cnt[k] = v;
                else m_err[k] = 1'b1;
            end else if (inc && !dec) begin
                m_cnt[k] = (m_cnt[k] + 1) % m_wrap[k];
            end else if (dec && !inc) begin
                m_cnt[k] = (m_cnt[k] + m_wrap[k] - 1) % m_wrap[k];
            end else if (en) begin
                m_carry[k] = (m_cnt[k] == m_wrap[k] - 1);
                m_cnt[k] = (m_cnt[k] + 1) % m_wrap[k];
            end
        end
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic apply_rst(input bit with_load);
        rst = 1'b1;
        drive(0, with_load, 0, 0, 2, 3);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0;
            m_carry[k] = 1'b0;
            m_err[k] = 1'b0;
        end
    endtask

    task automatic test_reset();
        mode12 = 1'b0;
        apply_rst(0);
        n_cmp++;
        if (got_a() !== 11'h000) begin
            n_bad++;
            $display("FAIL reset_a got=%h exp=%h", got_a(), 11'h000);
        end
        n_cmp++;
        if (got_b() !== 11'h000) begin
            n_bad++;
            $display("FAIL reset_b got=%h exp=%h", got_b(), 11'h000);
        end
    endtask

    task automatic test_rollover();
        cyc(0, 1, 0, 0, 2, 3);
        n_cmp++;
        if (got_a() !== {4'd2, 4'd3, 3'b000}) begin
            n_bad++;
            $display("FAIL load23 got=%h exp=%h", got_a(), {4'd2, 4'd3, 3'b000});
        end
        cyc(1, 0, 0, 0, 0, 0);
        n_cmp++;
        if (got_a() !== {4'd0, 4'd0, 3'b010}) begin
            n_bad++;
            $display("FAIL wrap_carry got=%h exp=%h", got_a(), {4'd0, 4'd0, 3'b010});
        end
        cyc(0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (got_a() !== exp_vec(0) || a.day_carry !== 1'b0) begin
            n_bad++;
            $display("FAIL carry_one_cycle got=%h exp=%h", got_a(), exp_vec(0));
        end
    endtask

    task automatic test_mode12();
        int          hv[4] = '{0, 12, 13, 23};
        logic [10:0] ev[4] = '{{4'd1, 4'd2, 3'b000}, {4'd1, 4'd2, 3'b100},
                               {4'd0, 4'd1, 3'b100}, {4'd1, 4'd1, 3'b100}};
        mode12 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 0, 0, hv[i] / 10, hv[i] % 10);
            n_cmp++;
            if (got_a() !== ev[i] || got_a() !== exp_vec(0)) begin
                n_bad++;
                $display("FAIL mode12_%0d got=%h exp=%h", hv[i], got_a(), ev[i]);
            end
        end
        mode12 = 1'b0;
        a.mode12 = 1'b0;
        #1;
        n_cmp++;
        if (got_a() !== {4'd2, 4'd3, 3'b000}) begin
            n_bad++;
            $display("FAIL mode12_comb got=%h exp=%h", got_a(), {4'd2, 4'd3, 3'b000});
        end
    endtask

    task automatic test_load_err();
        int tv[2] = '{2, 0};
        int uv[2] = '{4, 10};
        cyc(0, 1, 0, 0, 1, 5);
        for (int i = 0; i < 2; i++) begin
            cyc(0, 1, 0, 0, tv[i], uv[i]);
            n_cmp++;
            if (got_a() !== {4'd1, 4'd5, 3'b001}) begin
                n_bad++;
                $display("FAIL load_rej_%0d got=%h exp=%h", i, got_a(), {4'd1, 4'd5, 3'b001});
            end
            cyc(0, 0, 0, 0, 0, 0);
            n_cmp++;
            if (a.load_err !== 1'b0 || got_a() !== exp_vec(0)) begin
                n_bad++;
                $display("FAIL load_err_pulse_%0d got=%h exp=%h", i, got_a(), exp_vec(0));
            end
        end
    endtask

    task automatic test_incdec();
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        n_cmp++;
        if (got_a() !== {4'd2, 4'd3, 3'b000}) begin
            n_bad++;
            $display("FAIL dec_wrap got=%h exp=%h", got_a(), {4'd2, 4'd3, 3'b000});
        end
        cyc(0, 0, 1, 0, 0, 0);
        n_cmp++;
        if (got_a() !== {4'd0, 4'd0, 3'b000}) begin
            n_bad++;
            $display("FAIL inc_wrap got=%h exp=%h", got_a(), {4'd0, 4'd0, 3'b000});
        end
        cyc(1, 0, 1, 1, 0, 0);
        n_cmp++;
        if (got_a() !== {4'd0, 4'd1, 3'b000}) begin
            n_bad++;
            $display("FAIL incdec_cancel got=%h exp=%h", got_a(), {4'd0, 4'd1, 3'b000});
        end
        cyc(1, 0, 1, 0, 0, 0);
        n_cmp++;
        if (got_a() !== exp_vec(0)) begin
            n_bad++;
            $display("FAIL inc_over_en got=%h exp=%h", got_a(), exp_vec(0));
        end
    endtask

    task automatic test_priority();
        cyc(0, 1, 0, 0, 2, 3);
        cyc(1, 1, 0, 0, 0, 7);
        n_cmp++;
        if (got_a() !== {4'd0, 4'd7, 3'b000}) begin
            n_bad++;
            $display("FAIL load_over_en got=%h exp=%h", got_a(), {4'd0, 4'd7, 3'b000});
        end
        apply_rst(1);
        n_cmp++;
        if (got_a() !== 11'h000) begin
            n_bad++;
            $display("FAIL rst_over_load got=%h exp=%h", got_a(), 11'h000);
        end
    endtask

    task automatic test_wrap12();
        apply_rst(0);
        cyc(0, 1, 0, 0, 1, 1);
        n_cmp++;
        if (got_b() !== {4'd1, 4'd1, 3'b000}) begin
            n_bad++;
            $display("FAIL w12_load11 got=%h exp=%h", got_b(), {4'd1, 4'd1, 3'b000});
        end
        cyc(1, 0, 0, 0, 0, 0);
        n_cmp++;
        if (got_b() !== {4'd0, 4'd0, 3'b010}) begin
            n_bad++;
            $display("FAIL w12_wrap got=%h exp=%h", got_b(), {4'd0, 4'd0, 3'b010});
        end
        mode12 = 1'b1;
        cyc(0, 1, 0, 0, 1, 2);
        n_cmp++;
        if (got_b() !== {4'd0, 4'd0, 3'b001}) begin
            n_bad++;
            $display("FAIL w12_rej12 got=%h exp=%h", got_b(), {4'd0, 4'd0, 3'b001});
        end
        mode12 = 1'b0;
    endtask

    task automatic test_random();
        int t;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) mode12 = ~mode12;
            t = ($urandom_range(0, 7) == 0) ? $urandom_range(3, 15) : $urandom_range(0, 2);
            cyc($urandom_range(0, 99) < 45, $urandom_range(0, 9) == 0,
                $urandom_range(0, 6) == 0, $urandom_range(0, 6) == 0,
                t, $urandom_range(0, 11));
            n_cmp++;
            if (got_a() !== exp_vec(0)) begin
                n_bad++;
                $display("FAIL rand_a_%0d got=%h exp=%h", i, got_a(), exp_vec(0));
            end
            n_cmp++;
            if (got_b() !== exp_vec(1)) begin
                n_bad++;
                $display("FAIL rand_b_%0d got=%h exp=%h", i, got_b(), exp_vec(1));
            end
        end
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        test_reset();
        test_rollover();
        test_mode12();
        test_load_err();
        test_incdec();
        test_priority();
        test_wrap12();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
